hsfir_param: RTL and testbench



---
 rtl/hsfir_param.sv | 124 ++++++++++++
 tb/tb_hsfir_param.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/hsfir_param.sv
// hsfir_param: parametrised half-band FIR with symmetric pre-add, 4-edge pipeline, optional decimate-by-2.
// Define HSFIR_CLIP_COUNT_EN to add the saturating o_clip_count output.
module hsfir_param #(
   parameter int                      IW       = 8,
   parameter int                      OW       = 8,
   parameter int                      CW       = 12,
   parameter int                      K        = 3,
   parameter logic signed [K*CW-1:0]  COEFFS   = {12'sd610, -12'sd116, 12'sd18},
   parameter int                      DECIMATE = 0
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_valid,
   input  logic signed [IW-1:0] i_data,
   output logic                 o_valid,
   output logic signed [OW-1:0] o_data
`ifdef HSFIR_CLIP_COUNT_EN
   ,
   output logic [15:0]          o_clip_count
`endif
);

   localparam int NTAPS = 4*K - 1;
   localparam int PW    = IW + 1;
   localparam int MW    = IW + CW + 1;
   localparam int SW    = IW + CW + 1 + $clog2(K+1);
   localparam int RW    = SW + 1;

   localparam logic signed [RW-1:0] HALF = RW'(2**(CW-2));
   localparam logic signed [RW-1:0] OMAX = RW'((2**(OW-1)) - 1);
   localparam logic signed [RW-1:0] OMIN = RW'(-(2**(OW-1)));

   function automatic logic signed [CW-1:0] coef(input int k);
      return COEFFS[k*CW +: CW];
   endfunction

   logic signed [IW-1:0] dly [NTAPS];
   logic signed [PW-1:0] pre [K];
   logic signed [MW-1:0] mul [K];
   logic signed [IW-1:0] ctr_p, ctr_m;
   logic signed [SW-1:0] sum_c, sum_s;
   logic signed [RW-1:0] rnd;
   logic signed [OW-1:0] sat;
   logic                 clip_hi, clip_lo;
   logic                 phase, take;
   logic                 vld_x, vld_p, vld_m, vld_s;

   // In decimate mode only the second sample of each accepted pair is tagged for output.
   assign take = i_valid & ((DECIMATE == 0) | phase);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NTAPS; i++) dly[i] <= '0;
         phase <= 1'b0;
      end else if (i_valid) begin
         dly[0] <= i_data;
         for (int i = 1; i < NTAPS; i++) dly[i] <= dly[i-1];
         phase <= ~phase;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int k = 0; k < K; k++) begin
            pre[k] <= '0;
            mul[k] <= '0;
         end
         ctr_p <= '0;
         ctr_m <= '0;
         sum_s <= '0;
         vld_x <= 1'b0;
         vld_p <= 1'b0;
         vld_m <= 1'b0;
         vld_s <= 1'b0;
      end else begin
         for (int k = 0; k < K; k++) begin
            pre[k] <= PW'(dly[2*k]) + PW'(dly[NTAPS-1-2*k]);
            mul[k] <= MW'(pre[k]) * MW'(coef(k));
         end
         ctr_p <= dly[2*K-1];
         ctr_m <= ctr_p;
         sum_s <= sum_c;
         vld_x <= take;
         vld_p <= vld_x;
         vld_m <= vld_p;
         vld_s <= vld_m;
      end
   end

   // Center tap is exactly 0.5 in Q1.(CW-1), so it becomes a shift rather than a multiply.
   always_comb begin
      sum_c = SW'(ctr_m) <<< (CW-2);
      for (int k = 0; k < K; k++) sum_c = sum_c + SW'(mul[k]);
   end

   always_comb begin
      rnd     = (RW'(sum_s) + HALF) >>> (CW-1);
      clip_hi = (rnd > OMAX);
      clip_lo = (rnd < OMIN);
      sat     = OW'(rnd);
      if (clip_hi) sat = OW'(OMAX);
      if (clip_lo) sat = OW'(OMIN);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_valid <= vld_s;
         if (vld_s) o_data <= sat;
      end
   end

`ifdef HSFIR_CLIP_COUNT_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         o_clip_count <= '0;
      else if (vld_s && (clip_hi || clip_lo) && (o_clip_count != 16'hFFFF))
         o_clip_count <= o_clip_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_hsfir_param.sv
// Directed bench for hsfir_param: impulse, DC, valid gaps, saturation, mid-stream reset, decimation.
// Two instances share the stimulus: default build and DECIMATE=1.
module tb_hsfir_param;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic signed [7:0] in_data = '0;
   logic              out_valid, dec_valid;
   logic signed [7:0] out_data, dec_data;
`ifdef HSFIR_CLIP_COUNT_EN
   logic [15:0]       clip_count, dec_clip_count;
`endif

   int checks = 0;
   int errors = 0;

   int imp     [11] = '{1, 0, -4, 0, 19, 32, 19, 0, -4, 0, 1};
   int sat_in  [11] = '{127, 0, -128, 0, 127, 127, 127, 0, -128, 0, 127};
   int sat_out [11] = '{1, 0, -8, 0, 46, 65, -6, -71, -16, 101, 127};
   int dec_out [11] = '{0, 0, 32, 0, 0, 0, 0, 0, 0, 0, 0};

   always #5 clk = ~clk;

   hsfir_param dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(in_valid), .i_data(in_data),
      .o_valid(out_valid), .o_data(out_data)
`ifdef HSFIR_CLIP_COUNT_EN
      , .o_clip_count(clip_count)
`endif
   );

   hsfir_param #(.DECIMATE(1)) dut_dec (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(in_valid), .i_data(in_data),
      .o_valid(dec_valid), .o_data(dec_data)
`ifdef HSFIR_CLIP_COUNT_EN
      , .o_clip_count(dec_clip_count)
`endif
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are read on the next falling edge.
   task automatic step(input logic v, input int d);
      in_valid = v;
      in_data  = 8'(d);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      do_reset();
      chk("reset_valid", 32'(out_valid), 0);
      chk("reset_data", 32'(out_data), 0);
      chk("reset_dec_valid", 32'(dec_valid), 0);
      chk("reset_dec_data", 32'(dec_data), 0);
`ifdef HSFIR_CLIP_COUNT_EN
      chk("reset_clip", 32'(clip_count), 0);
`endif

      // Impulse: first o_valid exactly 4 edges after the 64 is accepted.
      for (int c = 0; c < 15; c++) begin
         step(c < 11, (c == 0) ? 64 : 0);
         chk("imp_valid", 32'(out_valid), (c >= 4) ? 1 : 0);
         chk("imp_data", 32'(out_data), (c >= 4) ? imp[c-4] : 0);
      end

      // DC: unity gain once the transient has left the delay line.
      for (int c = 0; c < 24; c++) begin
         step(c < 20, 100);
         chk("dc_valid", 32'(out_valid), (c >= 4) ? 1 : 0);
         if (c >= 14) chk("dc_data", 32'(out_data), 100);
      end

      // Valid gaps propagate as output gaps; o_data holds between pulses.
      do_reset();
      for (int c = 0; c < 25; c++) begin
         step((c < 22) && (c % 2 == 0), (c == 0) ? 64 : 0);
         chk("gap_valid", 32'(out_valid), (c >= 4 && c % 2 == 0) ? 1 : 0);
         chk("gap_data", 32'(out_data), (c >= 4) ? imp[(c-4)/2] : 0);
      end

      // Saturation: only the 11th output (R=156) clips.
      do_reset();
      for (int c = 0; c < 15; c++) begin
         step(c < 11, (c < 11) ? sat_in[c] : 0);
         chk("sat_valid", 32'(out_valid), (c >= 4) ? 1 : 0);
         chk("sat_data", 32'(out_data), (c >= 4) ? sat_out[c-4] : 0);
`ifdef HSFIR_CLIP_COUNT_EN
         chk("sat_clip", 32'(clip_count), (c >= 14) ? 1 : 0);
`endif
      end

      // Mid-stream reset two edges after acceptance, with a sample offered during reset.
      step(1'b1, 64);
      chk("mid_pre_valid", 32'(out_valid), 0);
      step(1'b0, 0);
      step(1'b0, 0);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'sd50;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_data", 32'(out_data), 0);
`ifdef HSFIR_CLIP_COUNT_EN
      chk("mid_rst_clip", 32'(clip_count), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step(1'b0, 0);
         chk("mid_idle_valid", 32'(out_valid), 0);
         chk("mid_idle_data", 32'(out_data), 0);
      end
      for (int c = 0; c < 15; c++) begin
         step(c < 11, (c == 0) ? 64 : 0);
         chk("mid_imp_valid", 32'(out_valid), (c >= 4) ? 1 : 0);
         chk("mid_imp_data", 32'(out_data), (c >= 4) ? imp[c-4] : 0);
      end
`ifdef HSFIR_CLIP_COUNT_EN
      chk("mid_imp_clip", 32'(clip_count), 0);
`endif

      // Decimate-by-2: outputs on the 2nd, 4th, ... accepted samples.
      do_reset();
      for (int c = 0; c < 26; c++) begin
         step(c < 22, (c == 0) ? 64 : 0);
         chk("dec_valid", 32'(dec_valid), (c >= 5 && c % 2 == 1) ? 1 : 0);
         chk("dec_data", 32'(dec_data), (c >= 5) ? dec_out[(c-5)/2] : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
